// File: rtl/unified_memory_arbiter_pkg.sv
// Shared encodings and legal parameter ranges for the unified memory arbiter.
package unified_memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int MEM_LATENCY_MIN  = 1;
  localparam int MEM_LATENCY_MAX  = 4;
  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 15;

  localparam int LAT_CNT_W    = 3;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/unified_memory_arbiter_if.sv
// Requester and memory-side signal bundle; slave is the arbiter's view, master the environment's.
interface unified_memory_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_valid;
  logic                  if_stall;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_valid;
  logic                  d_stall;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_memory_arbiter_arb_priority_select.sv
// Owner choice between IF and data requesters, with a saturating counter that bounds IF starvation.
module arb_priority_select
  import unified_memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_sample,
  input  logic   i_if_req,
  input  logic   i_d_req,
  output logic   o_grant,
  output owner_t o_owner
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_if_wins;

  // Data normally wins; IF takes the grant once it has been passed over LIMIT times in a row.
  assign w_if_wins = i_if_req && (!i_d_req || (r_starve_cnt == LIMIT));
  assign o_grant   = i_if_req || i_d_req;
  assign o_owner   = w_if_wins ? OWN_IF : OWN_D;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (i_sample) begin
      if (i_if_req && i_d_req && !w_if_wins)
        r_starve_cnt <= (r_starve_cnt == LIMIT) ? LIMIT : r_starve_cnt + 1'b1;
      else
        r_starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/unified_memory_arbiter.sv
// Serialises IF fetches and data loads/stores onto one single-port synchronous memory.
module unified_memory_arbiter
  import unified_memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic                     clk,
  input logic                     reset,
  unified_memory_arbiter_if.slave bus
);

  state_t                r_state;
  state_t                w_next_state;
  owner_t                r_owner;
  owner_t                w_owner;
  logic                  w_grant;
  logic                  w_load;
  logic                  w_capture;
  logic [LAT_CNT_W-1:0]  r_lat_cnt;

  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_if_valid;
  logic                  r_d_valid;

  arb_priority_select #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_sel (
    .clk      (clk),
    .reset    (reset),
    .i_sample (r_state == IDLE),
    .i_if_req (bus.if_req),
    .i_d_req  (bus.d_req),
    .o_grant  (w_grant),
    .o_owner  (w_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant) w_next_state = ISSUE;
      ISSUE:   w_next_state = WAIT;
      WAIT:    if (r_lat_cnt == LAT_CNT_W'(1)) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE:    w_load    = w_grant;
      WAIT:    w_capture = (r_lat_cnt == LAT_CNT_W'(1));
      default: ;
    endcase
  end

  // Request fields are latched at grant so later changes by the requester have no effect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_IF;
      r_lat_cnt   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
    end else begin
      r_mem_en   <= w_load;
      r_mem_we   <= w_load && (w_owner == OWN_D) && bus.d_we;
      r_if_valid <= w_capture && (r_owner == OWN_IF);
      r_d_valid  <= w_capture && (r_owner == OWN_D);
      if (w_load) begin
        r_owner     <= w_owner;
        r_mem_addr  <= (w_owner == OWN_D) ? bus.d_addr : bus.if_addr;
        r_mem_wdata <= (w_owner == OWN_D) ? bus.d_wdata : '0;
      end
      if (r_state == ISSUE)
        r_lat_cnt <= LAT_CNT_W'(MEM_LATENCY);
      else if (r_state == WAIT)
        r_lat_cnt <= r_lat_cnt - 1'b1;
      if (w_capture) begin
        if (r_owner == OWN_IF) r_if_rdata <= bus.mem_rdata;
        else                   r_d_rdata  <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_valid   = r_d_valid;
  assign bus.if_stall  = bus.if_req && !r_if_valid;
  assign bus.d_stall   = bus.d_req && !r_d_valid;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench: one arbiter with MEM_LATENCY=1/STARVE_LIMIT=2, one with MEM_LATENCY=3.
module tb_unified_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  unified_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
  unified_memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

  unified_memory_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(2)
  ) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

  unified_memory_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)
  ) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h8C02_0004;
      32'h0000_0200: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory models: read data is only correct exactly MEM_LATENCY cycles after mem_en.
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    b1.mem_rdata <= (b1.mem_en && !b1.mem_we) ? mem_word(b1.mem_addr) : 32'hBAD0_0001;
    p1           <= (b3.mem_en && !b3.mem_we) ? mem_word(b3.mem_addr) : 32'hBAD0_0003;
    p2           <= p1;
    b3.mem_rdata <= p2;
  end

  task automatic test_reset;
    logic [133:0] got1, got3;
    @(negedge clk);
    got1 = {b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.if_rdata, b1.d_rdata,
            b1.if_valid, b1.d_valid, b1.if_stall, b1.d_stall};
    got3 = {b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata, b3.if_rdata, b3.d_rdata,
            b3.if_valid, b3.d_valid, b3.if_stall, b3.d_stall};
    n_chk++;
    if (got1 !== '0) begin n_fail++; $display("FAIL reset_dut1: got %h want 0", got1); end
    n_chk++;
    if (got3 !== '0) begin n_fail++; $display("FAIL reset_dut3: got %h want 0", got3); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({b1.mem_en, b3.mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle_mem_en: got %b want 00", {b1.mem_en, b3.mem_en});
    end
  endtask

  task automatic test_if_read;
    logic [4:0] got, exp;
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = 32'h40;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = {b1.mem_en, b1.mem_we, b1.if_valid, b1.if_stall, b1.d_valid};
      exp = {k == 1, 1'b0, k == 3, k < 3, 1'b0};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL if_read_ctl cyc%0d: got %b want %b", k, got, exp);
      end
      if (k == 1) begin
        n_chk++;
        if (b1.mem_addr !== 32'h40) begin
          n_fail++; $display("FAIL if_read_addr: got %h want 00000040", b1.mem_addr);
        end
      end
      if (k == 3) begin
        n_chk++;
        if (b1.if_rdata !== 32'h8C02_0004) begin
          n_fail++; $display("FAIL if_read_rdata: got %h want 8c020004", b1.if_rdata);
        end
        b1.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_store;
    logic [5:0] got, exp;
    @(posedge clk); #1;
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h100; b1.d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      got = {b1.mem_en, b1.mem_we, b1.d_valid, b1.d_stall, b1.if_valid, b1.if_stall};
      exp = {k == 1, k == 1, k == 3, k < 3, 1'b0, 1'b0};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL store_ctl cyc%0d: got %b want %b", k, got, exp);
      end
      if (k == 1) begin
        n_chk++;
        if ({b1.mem_addr, b1.mem_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin
          n_fail++; $display("FAIL store_bus: got %h/%h want 00000100/deadbeef", b1.mem_addr, b1.mem_wdata);
        end
      end
      if (k == 3) begin b1.d_req = 1'b0; b1.d_we = 1'b0; end
    end
  endtask

  task automatic test_simultaneous;
    logic [4:0] got, exp;
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = 32'h44; b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      got = {b1.mem_en, b1.d_valid, b1.if_valid, b1.d_stall, b1.if_stall};
      exp = {(k == 1) || (k == 5), k == 3, k == 7, k < 3, k < 7};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL simul_ctl cyc%0d: got %b want %b", k, got, exp);
      end
      if (k == 1 || k == 5) begin
        n_chk++;
        if (b1.mem_addr !== ((k == 1) ? 32'h80 : 32'h44)) begin
          n_fail++; $display("FAIL simul_addr cyc%0d: got %h", k, b1.mem_addr);
        end
      end
      if (k == 3) begin
        n_chk++;
        if (b1.d_rdata !== 32'hA5A5_0080) begin
          n_fail++; $display("FAIL simul_d_rdata: got %h want a5a50080", b1.d_rdata);
        end
        b1.d_req = 1'b0;
      end
      if (k == 7) begin
        n_chk++;
        if (b1.if_rdata !== 32'hA5A5_0044) begin
          n_fail++; $display("FAIL simul_if_rdata: got %h want a5a50044", b1.if_rdata);
        end
        b1.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_starvation;
    logic [5:0] exp_if = 6'b100100;
    logic [2:0] got, exp;
    int         idx;
    @(posedge clk); #1;
    b1.if_req = 1'b1; b1.if_addr = 32'h10; b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h20;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      idx = k / 4;
      got = {b1.mem_en, b1.d_valid, b1.if_valid};
      exp = {(k % 4) == 1, ((k % 4) == 3) && !exp_if[idx], ((k % 4) == 3) && exp_if[idx]};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL starve_ctl cyc%0d: got %b want %b", k, got, exp);
      end
      if ((k % 4) == 1) begin
        n_chk++;
        if (b1.mem_addr !== (exp_if[idx] ? 32'h10 : 32'h20)) begin
          n_fail++; $display("FAIL starve_order grant%0d: got addr %h", idx, b1.mem_addr);
        end
      end
    end
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency3;
    logic [3:0] got, exp;
    int         n_en = 0;
    @(posedge clk); #1;
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h200;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (b3.mem_en) n_en++;
      got = {b3.mem_en, b3.d_valid, b3.d_stall, b3.if_valid};
      exp = {k == 1, k == 5, k < 5, 1'b0};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL lat3_ctl cyc%0d: got %b want %b", k, got, exp);
      end
      if (k == 5) begin
        n_chk++;
        if (b3.d_rdata !== 32'h1234_5678) begin
          n_fail++; $display("FAIL lat3_rdata: got %h want 12345678", b3.d_rdata);
        end
        b3.d_req = 1'b0;
      end
    end
    n_chk++;
    if (n_en != 1) begin n_fail++; $display("FAIL lat3_mem_en_count: got %0d want 1", n_en); end
  endtask

  task automatic test_reset_in_wait;
    logic [131:0] got;
    @(posedge clk); #1;
    b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (b1.mem_en !== 1'b1) begin n_fail++; $display("FAIL rstwait_issue: got %b want 1", b1.mem_en); end
    @(negedge clk);
    reset = 1'b1; b1.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    got = {b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata, b1.if_rdata, b1.d_rdata,
           b1.if_valid, b1.d_valid};
    n_chk++;
    if (got !== '0) begin n_fail++; $display("FAIL rstwait_outputs: got %h want 0", got); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_chk++;
      if ({b1.mem_en, b1.d_valid, b1.if_valid} !== 3'b000) begin
        n_fail++; $display("FAIL rstwait_quiet cyc%0d: got %b want 000", k, {b1.mem_en, b1.d_valid, b1.if_valid});
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0; b3.d_addr = '0; b3.d_wdata = '0;
    #2 reset = 1'b1;
    test_reset();
    test_if_read();
    test_store();
    test_simultaneous();
    test_starvation();
    test_latency3();
    test_reset_in_wait();
    test_if_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters: instruction fetch (IF) and data access (MEM stage loads/stores).
- Lets the pipeline run on a unified instruction/data memory instead of separate instruction and data memories.
- Serialises the two requesters' accesses and returns per-requester stall and valid signals.
- The PC/IF_ID hold logic and the MEM-stage freeze consume the stall signals.

Parameters:
- ADDR_WIDTH, 32: byte address width on all ports.
- DATA_WIDTH, 32: data word width.
- MEM_LATENCY, 1: cycles from the mem_en cycle to mem_rdata valid; legal range 1..4.
- STARVE_LIMIT, 4: maximum consecutive data grants while if_req is pending; the next grant goes to IF. Legal range 1..15.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- if_req, input, 1: IF requests a read. Held high until if_valid.
- if_addr, input, ADDR_WIDTH: fetch address. Stable while if_req is high.
- if_rdata, output, DATA_WIDTH: fetched word. Meaningful only while if_valid is high.
- if_valid, output, 1: one-cycle completion pulse for IF.
- if_stall, output, 1: if_req && !if_valid.
- d_req, input, 1: data requester access request. Held high until d_valid.
- d_we, input, 1: 1 = write, 0 = read. Stable while d_req is high.
- d_addr, input, ADDR_WIDTH: data address.
- d_wdata, input, DATA_WIDTH: store data.
- d_rdata, output, DATA_WIDTH: load data. Meaningful only while d_valid is high.
- d_valid, output, 1: one-cycle completion pulse for data.
- d_stall, output, 1: d_req && !d_valid.
- mem_en, output, 1: memory access strobe. One cycle per transaction.
- mem_we, output, 1: memory write enable. Qualified by mem_en.
- mem_addr, output, ADDR_WIDTH: memory address.
- mem_wdata, output, DATA_WIDTH: memory write data.
- mem_rdata, input, DATA_WIDTH: memory read data. Valid MEM_LATENCY cycles after mem_en.

Behaviour:
- Reset (asynchronous): state=IDLE, starve_cnt=0, lat_cnt=0, owner=IF. All registered outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_valid, d_valid. Any in-flight transaction is discarded and produces no valid pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - Otherwise pick the owner, register the chosen request onto the mem_* outputs and go to ISSUE.
  - Owner choice: data wins if d_req is high, unless if_req is high and starve_cnt == STARVE_LIMIT, in which case IF wins. IF wins if only if_req is high.
- ISSUE (one cycle):
  - mem_en=1. mem_we=d_we for a data owner, 0 for an IF owner.
  - lat_cnt loaded with MEM_LATENCY. Next state is WAIT.
- WAIT:
  - mem_en=0 and mem_we=0; mem_addr and mem_wdata hold.
  - lat_cnt decrements each cycle. When lat_cnt==1, capture mem_rdata into the owner's rdata register and go to RESP.
  - For writes, the capture still happens and its value is don't-care.
- RESP (one cycle):
  - The owner's valid output is 1.
  - Requests are not sampled in this cycle, which prevents re-granting a request that is still held. Next state is IDLE.
- Latency:
  - req-to-valid = MEM_LATENCY + 3 cycles when uncontended (IDLE, ISSUE, WAIT×MEM_LATENCY, RESP).
  - Minimum spacing between consecutive mem_en pulses = MEM_LATENCY + 3.
- starve_cnt update, performed on each grant in IDLE:
  - Data grant while if_req is high: starve_cnt+1, saturating at STARVE_LIMIT.
  - IF grant, or any cycle in IDLE with if_req low: starve_cnt=0.
- rdata registers hold their last value outside their valid pulse.
- Requester protocol errors:
  - A requester that drops req mid-transaction still gets its valid pulse, which it ignores; the arbiter does not abort.
  - Changing addr or wdata mid-transaction is undefined. The arbiter latches them at grant, so they have no effect.
- if_valid and d_valid are never high in the same cycle. Exactly one mem_en pulse is issued per valid pulse.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3).
  - Owner encoding (OWN_IF=1'b0, OWN_D=1'b1).
  - MEM_LATENCY and STARVE_LIMIT legal-range constants.
- Sub-module: arb_priority_select (combinational owner choice plus saturating starve counter). Instantiated once.
- The FSM and datapath registers stay in the top module.

Test Plan:
- Reset in WAIT: reset held for 1 cycle while a d_req read is in WAIT → all outputs are 0 next cycle, no d_valid pulse follows, and state is IDLE.
- Single IF read (MEM_LATENCY=1): if_req=1, if_addr=0x40, memory returns 0x8C020004 → mem_en pulses with mem_addr=0x40 in cycle 1. if_valid=1 with if_rdata=0x8C020004 in cycle 3. if_stall=1 in cycles 0–2 and 0 in cycle 3.
- Data store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → one mem_en with mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF. d_valid pulses after 4 cycles. No IF activity.
- Simultaneous requests: if_req and d_req both asserted at cycle 0 → data is served first (d_valid at cycle 3), then IF (if_valid at cycle 7). mem_en is high in cycles 1 and 5.
- Starvation (STARVE_LIMIT=2): if_req is held high while d_req is re-asserted continuously → grant order is D, D, IF, D, D, IF. starve_cnt never exceeds 2.
- MEM_LATENCY=3 read: d_req read of 0x200 returns 0x12345678 → d_valid 6 cycles after d_req. mem_en is high for exactly 1 cycle. if_valid stays 0.
